// File: rtl/if_fetch.sv
// Instruction-fetch stage: sequential PC generation, request/grant memory
// handshake with in-order responses, and a small {pc, inst} buffer that
// feeds decode through a valid/ready handshake. A redirect empties the
// buffer and arranges for every response still in flight to be discarded.
module if_fetch #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    input  logic        id_ready_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      pc_mem   [FIFO_DEPTH];
    logic [31:0]      inst_mem [FIFO_DEPTH];

    logic [CNT_W:0]   credit_used;
    logic             grant;
    logic             resp_drop;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] outstanding_after_resp;
    logic [CNT_W-1:0] outstanding_next;
    logic [31:0]      redirect_base;

    // Credit check, handshake qualifiers and head-of-buffer outputs.
    // Responses that will be kept (outstanding - drop) plus buffered entries
    // must leave room, so a returning response can never find the buffer full.
    always_comb begin
        credit_used            = {1'b0, outstanding - drop_cnt} + {1'b0, fifo_count};
        imem_req_o             = rst && !redirect_i && (outstanding < DEPTH_C)
                                 && (credit_used < {1'b0, DEPTH_C});
        imem_addr_o            = fetch_pc;
        grant                  = imem_req_o && imem_gnt_i;
        resp_drop              = imem_rvalid_i && (redirect_i || (drop_cnt != '0));
        push                   = imem_rvalid_i && !resp_drop;
        if_valid_o             = (fifo_count != '0);
        pop                    = if_valid_o && id_ready_i;
        outstanding_after_resp = outstanding - CNT_W'(imem_rvalid_i);
        outstanding_next       = outstanding_after_resp + CNT_W'(grant);
        redirect_base          = {redirect_pc_i[31:2], 2'b00};
        if_pc_o                = if_valid_o ? pc_mem[rd_ptr]   : 32'h0;
        if_inst_o              = if_valid_o ? inst_mem[rd_ptr] : 32'h0;
    end

    // Fetch and response PCs: advance on grant / kept response, reload on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
            end
        end
    end

    // In-flight bookkeeping: outstanding requests and responses still to discard.
    // On redirect every request left in flight after this cycle's response is stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_i) begin
            outstanding <= outstanding_after_resp;
            drop_cnt    <= outstanding_after_resp;
        end else begin
            outstanding <= outstanding_next;
            if (imem_rvalid_i && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    // Buffer pointers and occupancy; redirect empties the buffer outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Buffer storage; contents only matter behind a non-zero count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= resp_pc;
            inst_mem[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch: a latency-programmable in-order memory
// model feeds the main instance; a second instance exercises PC wrap-around
// from a non-zero reset address with hand-driven responses.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;

    logic        req2;
    logic [31:0] addr2;
    logic        gnt2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] inst2;
    logic        ready2;

    int n_checks;
    int n_fail;
    int lat;
    int cyc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic        next_rvalid;
    logic [31:0] next_rdata;

    if_fetch #(.FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .if_valid_o(if_valid), .if_pc_o(if_pc), .if_inst_o(if_inst),
        .id_ready_i(id_ready)
    );

    if_fetch #(.FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt2),
        .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
        .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
        .if_valid_o(valid2), .if_pc_o(pc2), .if_inst_o(inst2),
        .id_ready_i(ready2)
    );

    // Instruction word stored at a given address in the memory model.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a ^ 32'h1357_9BDF) + {a[15:0], 16'h0000};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // In-order memory model: record grants at mid-cycle, answer after lat cycles.
    initial begin
        req_t r;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        cyc         = 0;
        next_rvalid = 1'b0;
        next_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend.delete();
                next_rvalid = 1'b0;
            end else begin
                if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
                if (imem_req && imem_gnt) begin
                    r.addr = imem_addr;
                    r.due  = cyc + lat;
                    pend.push_back(r);
                end
                next_rvalid = 1'b0;
                if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                    next_rvalid = 1'b1;
                    next_rdata  = inst_of(pend[0].addr);
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            imem_rvalid = next_rvalid;
            imem_rdata  = next_rvalid ? next_rdata : 32'h0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller just after the edge that opens cycle 0 with reset released.
    task automatic apply_reset();
        rst      = 1'b0;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want 00000000", imem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", if_valid); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h want 00000000", if_pc); end
        n_checks++; if (if_inst !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_inst: got %h want 00000000", if_inst); end
        n_checks++; if (addr2 !== 32'hFFFF_FFF8) begin n_fail++; $display("[TB] FAIL reset_addr_wrap: got %h want fffffff8", addr2); end
        n_checks++; if (req2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_wrap: got %b want 0", req2); end
    endtask

    task automatic test_stream();
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin n_fail++; $display("[TB] FAIL stream_req c%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k)); end
            if (k < 2) begin
                n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_early_valid c%0d: got %b want 0", k, if_valid); end
            end else begin
                n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 2))) begin n_fail++; $display("[TB] FAIL stream_pc c%0d: got valid=%b pc=%h want valid=1 pc=%h", k, if_valid, if_pc, 32'(4 * (k - 2))); end
                n_checks++; if (if_inst !== inst_of(32'(4 * (k - 2)))) begin n_fail++; $display("[TB] FAIL stream_inst c%0d: got %h want %h", k, if_inst, inst_of(32'(4 * (k - 2)))); end
            end
            step();
        end
    endtask

    task automatic test_stall();
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b0;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== inst_of(32'h0)) begin n_fail++; $display("[TB] FAIL stall_head c%0d: got valid=%b pc=%h inst=%h want 1/00000000/%h", k, if_valid, if_pc, if_inst, inst_of(32'h0)); end
            end
            if (k >= 4) begin
                n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_credit c%0d: got req=%b want 0", k, imem_req); end
            end
            step();
        end
        id_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_inst !== inst_of(32'(4 * k))) begin n_fail++; $display("[TB] FAIL stall_drain %0d: got valid=%b pc=%h inst=%h want pc=%h", k, if_valid, if_pc, if_inst, 32'(4 * k)); end
            step();
        end
    endtask

    task automatic test_redirect_inflight();
        lat = 3; imem_gnt = 1'b1; id_ready = 1'b1;
        apply_reset();
        @(negedge clk);
        n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_c0: got req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
        step();
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_req_blocked: got %b want 0", imem_req); end
        step();
        redirect = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin n_fail++; $display("[TB] FAIL redir_target: got req=%b addr=%h want 1/00000100", imem_req, imem_addr); end
        for (int k = 3; k < 7; k++) begin
            if (k > 3) @(negedge clk);
            n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL redir_stale c%0d: got valid=%b pc=%h want 0/00000000", k, if_valid, if_pc); end
            step();
        end
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_0100 || if_inst !== inst_of(32'h100)) begin n_fail++; $display("[TB] FAIL redir_first: got valid=%b pc=%h inst=%h want 1/00000100/%h", if_valid, if_pc, if_inst, inst_of(32'h100)); end
        step();
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_0104 || if_inst !== inst_of(32'h104)) begin n_fail++; $display("[TB] FAIL redir_second: got valid=%b pc=%h inst=%h want 1/00000104/%h", if_valid, if_pc, if_inst, inst_of(32'h104)); end
        step();
    endtask

    task automatic test_redirect_full();
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b0;
        apply_reset();
        repeat (4) step();
        redirect = 1'b1; redirect_pc = 32'h2000_0042;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL full_before: got valid=%b pc=%h req=%b want 1/00000000/0", if_valid, if_pc, imem_req); end
        step();
        redirect = 1'b0;
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin n_fail++; $display("[TB] FAIL full_flushed: got valid=%b pc=%h inst=%h want 0/0/0", if_valid, if_pc, if_inst); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000_0040) begin n_fail++; $display("[TB] FAIL full_refetch: got req=%b addr=%h want 1/20000040", imem_req, imem_addr); end
        step();
        step();
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h2000_0040 || if_inst !== inst_of(32'h2000_0040)) begin n_fail++; $display("[TB] FAIL full_target: got valid=%b pc=%h inst=%h want 1/20000040/%h", if_valid, if_pc, if_inst, inst_of(32'h2000_0040)); end
        step();
    endtask

    task automatic test_pc_wrap();
        gnt2 = 1'b1; ready2 = 1'b1; rvalid2 = 1'b0;
        apply_reset();
        @(negedge clk);
        n_checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8) begin n_fail++; $display("[TB] FAIL wrap_addr0: got req=%b addr=%h want 1/fffffff8", req2, addr2); end
        step();
        rvalid2 = 1'b1; rdata2 = 32'hAAAA_0001;
        @(negedge clk);
        n_checks++; if (addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_addr1: got %h want fffffffc", addr2); end
        step();
        rdata2 = 32'hAAAA_0002;
        @(negedge clk);
        n_checks++; if (addr2 !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_addr2: got %h want 00000000", addr2); end
        n_checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFF8 || inst2 !== 32'hAAAA_0001) begin n_fail++; $display("[TB] FAIL wrap_pc0: got valid=%b pc=%h inst=%h want 1/fffffff8/aaaa0001", valid2, pc2, inst2); end
        step();
        rdata2 = 32'hAAAA_0003;
        @(negedge clk);
        n_checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || inst2 !== 32'hAAAA_0002) begin n_fail++; $display("[TB] FAIL wrap_pc1: got valid=%b pc=%h inst=%h want 1/fffffffc/aaaa0002", valid2, pc2, inst2); end
        step();
        rvalid2 = 1'b0;
        @(negedge clk);
        n_checks++; if (valid2 !== 1'b1 || pc2 !== 32'h0 || inst2 !== 32'hAAAA_0003) begin n_fail++; $display("[TB] FAIL wrap_pc2: got valid=%b pc=%h inst=%h want 1/00000000/aaaa0003", valid2, pc2, inst2); end
        step();
    endtask

    task automatic test_async_reset();
        lat = 3; imem_gnt = 1'b1; id_ready = 1'b1;
        apply_reset();
        repeat (5) step();
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin n_fail++; $display("[TB] FAIL areset_pre: got valid=%b pc=%h want 1/00000004", if_valid, if_pc); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin n_fail++; $display("[TB] FAIL areset_out: got valid=%b pc=%h inst=%h want 0/0/0", if_valid, if_pc, if_inst); end
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL areset_req: got req=%b addr=%h want 0/00000000", imem_req, imem_addr); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL areset_restart: got req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
        repeat (4) step();
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== inst_of(32'h0)) begin n_fail++; $display("[TB] FAIL areset_first: got valid=%b pc=%h inst=%h want 1/00000000/%h", if_valid, if_pc, if_inst, inst_of(32'h0)); end
        step();
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== inst_of(32'h4)) begin n_fail++; $display("[TB] FAIL areset_second: got valid=%b pc=%h inst=%h want 1/00000004/%h", if_valid, if_pc, if_inst, inst_of(32'h4)); end
        step();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        lat          = 1;
        rst          = 1'b1;
        imem_gnt     = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        id_ready     = 1'b1;
        gnt2         = 1'b0;
        rvalid2      = 1'b0;
        rdata2       = 32'h0;
        redirect2    = 1'b0;
        redirect_pc2 = 32'h0;
        ready2       = 1'b1;
        $display("[TB] if_fetch directed test start");
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_full();
        test_pc_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
